prog_loader: RTL and testbench

// - Write side of the byte-addressed program memory read by the fetch stage.
// - Accepts a byte stream (valid/ready) from the host link: a 2-byte length header
//   (big-endian), then N payload bytes.
// - Writes payload bytes to consecutive memory addresses; stream order == memory order,
//   so big-endian instruction words fetch unchanged.
// - Holds the harts off via busy; raises done when the image is complete.

---
 rtl/prog_loader.sv | 153 +++++++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: write side of the byte-addressed program memory.
// Takes a big-endian 16-bit length header and then the payload from a
// valid/ready byte stream. It writes the payload bytes to consecutive
// addresses starting at BASE_ADDR.
// Optional feature macro: CHECKSUM_EN (one trailing checksum byte; the
// payload plus that byte must sum to 0 mod 256).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                1-cycle pulse, begins a load when not busy
//   s_valid/s_data       stream byte in
//   s_ready              loader accepts s_data this cycle
//   mem_we/addr/wdata    registered byte write to program memory
//   busy, done, err      status; done/err held until next start/reset
module prog_loader #(
    parameter int unsigned Psize     = 512,
    parameter int unsigned n         = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         s_valid,
    input  logic [7:0]   s_data,
    output logic         s_ready,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [7:0]   mem_wdata,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR
    } state_t;

    localparam logic [31:0] LIMIT = 32'(Psize - BASE_ADDR);

`ifdef CHECKSUM_EN
    localparam state_t POST = CHECK;
`else
    localparam state_t POST = DONE;
`endif

    state_t      state;
    state_t      state_nx;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [15:0] len_full;
    logic        xfer;
    logic        last;
`ifdef CHECKSUM_EN
    logic [7:0]  sum_q;
    logic [7:0]  sum_chk;
`endif

    assign xfer     = s_valid & s_ready;
    // Full length as seen during the LEN_LO transfer itself
    assign len_full = {len_q[15:8], s_data};
    assign last     = (cnt_q == len_q - 16'd1);
`ifdef CHECKSUM_EN
    assign sum_chk  = sum_q + s_data;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_nx = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if ({16'd0, len_full} > LIMIT) state_nx = ERR;
                    else if (len_full == 16'd0)    state_nx = POST;
                    else                           state_nx = DATA;
                end
            end
            DATA: begin
                if (xfer && last) state_nx = POST;
            end
            CHECK: begin
`ifdef CHECKSUM_EN
                if (xfer) state_nx = (sum_chk == 8'd0) ? DONE : ERR;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, DATA, CHECK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header capture, write port, counters
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            cnt_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= n'(BASE_ADDR);
            mem_wdata <= '0;
`ifdef CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (start && !busy) begin
                len_q <= '0;
                cnt_q <= '0;
`ifdef CHECKSUM_EN
                sum_q <= '0;
`endif
            end
            if (state == LEN_HI && xfer) len_q[15:8] <= s_data;
            if (state == LEN_LO && xfer) len_q[7:0]  <= s_data;
            if (state == DATA && xfer) begin
                mem_we    <= 1'b1;
                mem_addr  <= n'(BASE_ADDR) + n'(cnt_q);
                mem_wdata <= s_data;
                cnt_q     <= cnt_q + 16'd1;
`ifdef CHECKSUM_EN
                sum_q     <= sum_q + s_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader.
// Write log is collected on the falling edge; checks are immediate asserts.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    int          gap    = 0;
    logic [7:0]  psum;

    logic [31:0] wa [0:599];
    logic [7:0]  wd [0:599];
    int          wn = 0;

    prog_loader #(.Psize(512), .n(32), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1 && wn < 600) begin
            wa[wn] = mem_addr;
            wd[wn] = mem_wdata;
            wn = wn + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        psum  = 8'd0;
    endtask

    task automatic put(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pay(input logic [7:0] b);
        put(b);
        psum = psum + b;
    endtask

    task automatic finish_img();
`ifdef CHECKSUM_EN
        put(8'd0 - psum);
`endif
    endtask

    task automatic chk_img(input string tag, input int m,
                           input logic [31:0] d);
        chk({tag, "_count"}, 64'(wn - m), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_wr"}, {wa[m+i], 24'd0, wd[m+i]},
                {32'(i), 24'd0, d[31-8*i -: 8]});
        end
    endtask

    initial begin
        int mark;
        int bad;
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        psum    = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic 4-byte image
        mark = wn;
        go();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ready", 64'(s_ready), 64'd1);
        put(8'h00); put(8'h04);
        pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00);
`ifndef CHECKSUM_EN
        chk("t1_last_we", 64'(mem_we), 64'd1);
        chk("t1_last_addr", 64'(mem_addr), 64'd3);
`endif
        finish_img();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_ready_end", 64'(s_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk_img("t1", mark, 32'h13000000);

        // Same image with 3-cycle gaps, plus a start while busy
        gap  = 3;
        mark = wn;
        go();
        put(8'h00); put(8'h04);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_busy_start", 64'(busy), 64'd1);
        pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00);
        finish_img();
        chk("t2_done", 64'(done), 64'd1);
        chk_img("t2", mark, 32'h13000000);
        gap = 0;

        // Overflow: 513 bytes
        mark = wn;
        go();
        chk("t3_clear_done", 64'(done), 64'd0);
        put(8'h02); put(8'h01);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_done", 64'(done), 64'd0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (2) @(negedge clk);
        chk("t3_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        chk("t3_writes", 64'(wn - mark), 64'd0);

        // Zero length
        mark = wn;
        go();
        chk("t4_clear_err", 64'(err), 64'd0);
        put(8'h00); put(8'h00);
        finish_img();
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t4_writes", 64'(wn - mark), 64'd0);

        // Reset after 2 of 4 payload bytes
        mark = wn;
        go();
        put(8'h00); put(8'h04);
        pay(8'hAA); pay(8'hBB);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_we", 64'(mem_we), 64'd0);
        chk("t5_ready", 64'(s_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_partial", 64'(wn - mark), 64'd2);
        mark = wn;
        go();
        put(8'h00); put(8'h04);
        pay(8'hA1); pay(8'hB2); pay(8'hC3); pay(8'hD4);
        finish_img();
        chk("t5_done", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        chk_img("t5", mark, 32'hA1B2C3D4);

        // Exactly Psize bytes is accepted
        mark = wn;
        go();
        put(8'h02); put(8'h00);
        chk("t6_no_err", 64'(err), 64'd0);
        for (int k = 0; k < 512; k++) pay(8'(k));
        finish_img();
        chk("t6_done", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        chk("t6_count", 64'(wn - mark), 64'd512);
        bad = 0;
        for (int k = 0; k < 512 && mark + k < 600; k++) begin
            if (wa[mark+k] !== 32'(k) || wd[mark+k] !== 8'(k)) bad++;
        end
        chk("t6_bad_writes", 64'(bad), 64'd0);
        chk("t6_top_addr", 64'(wa[mark+511]), 64'd511);

`ifdef CHECKSUM_EN
        mark = wn;
        go();
        put(8'h00); put(8'h02); put(8'h01); put(8'h02); put(8'hFD);
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_err", 64'(err), 64'd0);
        go();
        put(8'h00); put(8'h02); put(8'h01); put(8'h02); put(8'hFC);
        chk("t7_bad_err", 64'(err), 64'd1);
        chk("t7_bad_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("t7_writes", 64'(wn - mark), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
